// File: rtl/alu_ctrl_encoder.sv
// Purpose: validates (kind, ALUControl) requests, encodes them to alu_op/funct3/funct7 and queues them in order.
// Latency: a legal request accepted into an empty queue shows at the head on the next cycle (no bypass).
// Backpressure: in_ready drops only when the queue is full; illegal requests are accepted, counted and dropped.
module alu_ctrl_encoder #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_kind,
   input  logic [3:0]  in_ctrl,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [1:0]  out_alu_op,
   output logic [2:0]  out_funct3,
   output logic [6:0]  out_funct7,
   input  logic        clr_err,
   output logic        err_sticky,
   output logic [7:0]  err_count,
   output logic [15:0] enc_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [3:0] C_ADD  = 4'd0;
   localparam logic [3:0] C_SUB  = 4'd1;
   localparam logic [3:0] C_AND  = 4'd2;
   localparam logic [3:0] C_OR   = 4'd3;
   localparam logic [3:0] C_XOR  = 4'd4;
   localparam logic [3:0] C_SLT  = 4'd5;
   localparam logic [3:0] C_SLTU = 4'd6;
   localparam logic [3:0] C_SLL  = 4'd7;
   localparam logic [3:0] C_SRL  = 4'd8;
   localparam logic [3:0] C_SRA  = 4'd9;

   typedef struct packed {
      logic [1:0] alu_op;
      logic [2:0] funct3;
      logic [6:0] funct7;
   } enc_t;

   enc_t             mem_q [DEPTH];
   enc_t             enc_d;
   enc_t             head;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             err_sticky_q, err_sticky_d;
   logic [7:0]       err_count_q, err_count_d;
   logic [15:0]      enc_count_q, enc_count_d;
   logic [2:0]       f3;
   logic             legal;
   logic             accept, push, pop, illegal_acc;

   // Decode the request: funct3 lookup, per-kind legality and field encoding
   always_comb begin
      enc_d = '0;
      legal = 1'b0;
      case (in_ctrl)
         C_ADD, C_SUB: f3 = 3'b000;
         C_SLL:        f3 = 3'b001;
         C_SLT:        f3 = 3'b010;
         C_SLTU:       f3 = 3'b011;
         C_XOR:        f3 = 3'b100;
         C_SRL, C_SRA: f3 = 3'b101;
         C_OR:         f3 = 3'b110;
         C_AND:        f3 = 3'b111;
         default:      f3 = 3'b000;
      endcase
      case (in_kind)
         2'b00: begin
            legal        = (in_ctrl == C_ADD);
            enc_d.alu_op = 2'b00;
         end
         2'b01: begin
            legal        = (in_ctrl == C_SUB);
            enc_d.alu_op = 2'b01;
         end
         2'b10: begin
            legal        = (in_ctrl <= C_SRA);
            enc_d.alu_op = 2'b10;
            enc_d.funct3 = f3;
            enc_d.funct7 = (in_ctrl == C_SUB || in_ctrl == C_SRA) ? 7'b0100000 : 7'b0000000;
         end
         default: begin
            // I-type has no SUB encoding
            legal        = (in_ctrl <= C_SRA) && (in_ctrl != C_SUB);
            enc_d.alu_op = 2'b11;
            enc_d.funct3 = f3;
            enc_d.funct7 = (in_ctrl == C_SRA) ? 7'b0100000 : 7'b0000000;
         end
      endcase
   end

   // Handshake qualifiers; in_ready depends only on registered occupancy
   always_comb begin
      in_ready    = (count_q < DEPTH_C);
      out_valid   = (count_q != '0);
      accept      = in_valid && in_ready;
      push        = accept && legal;
      illegal_acc = accept && !legal;
      pop         = out_valid && out_ready;
   end

   // Next-state for pointers, occupancy and counters
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
      // A new error in the same cycle as a clear keeps the flag set
      err_sticky_d = illegal_acc ? 1'b1 : (clr_err ? 1'b0 : err_sticky_q);
      err_count_d  = (illegal_acc && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
      enc_count_d  = push ? enc_count_q + 16'd1 : enc_count_q;
   end

   // Control state with asynchronous reset; reset drops every queued entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_sticky_q <= 1'b0;
         err_count_q  <= '0;
         enc_count_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_sticky_q <= err_sticky_d;
         err_count_q  <= err_count_d;
         enc_count_q  <= enc_count_d;
      end
   end

   // Entry storage; contents are only observed through out_valid so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= enc_d;
      end
   end

   // Head fields forced to zero whenever the queue is empty
   always_comb begin
      head       = out_valid ? mem_q[rd_ptr_q] : '0;
      out_alu_op = head.alu_op;
      out_funct3 = head.funct3;
      out_funct7 = head.funct7;
      err_sticky = err_sticky_q;
      err_count  = err_count_q;
      enc_count  = enc_count_q;
   end

endmodule

// File: tb/tb_alu_ctrl_encoder.sv
module tb_alu_ctrl_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_kind;
   logic [3:0]  in_ctrl;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_alu_op;
   logic [2:0]  out_funct3;
   logic [6:0]  out_funct7;
   logic        clr_err;
   logic        err_sticky;
   logic [7:0]  err_count;
   logic [15:0] enc_count;

   int errors = 0;
   int checks = 0;

   alu_ctrl_encoder #(.DEPTH(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_kind    (in_kind),
      .in_ctrl    (in_ctrl),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_alu_op (out_alu_op),
      .out_funct3 (out_funct3),
      .out_funct7 (out_funct7),
      .clr_err    (clr_err),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .enc_count  (enc_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare valid + packed head fields {alu_op, funct3, funct7}
   task automatic check_head(input string tag, input logic vld, input logic [1:0] alu,
                             input logic [2:0] f3, input logic [6:0] f7);
      check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, vld});
      check({tag, ".fields"}, {20'd0, out_alu_op, out_funct3, out_funct7}, {20'd0, alu, f3, f7});
   endtask

   // Present one legal request with out_ready=1 and check it at the head one cycle later
   task automatic legal_vec(input logic [1:0] k, input logic [3:0] c, input logic [1:0] alu,
                            input logic [2:0] f3, input logic [6:0] f7);
      in_valid = 1'b1;
      in_kind  = k;
      in_ctrl  = c;
      tick();
      check_head($sformatf("legal k%0d c%0d", k, c), 1'b1, alu, f3, f7);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, ".fields"}, {20'd0, out_alu_op, out_funct3, out_funct7}, 32'd0);
      check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, ".err_sticky"}, {31'd0, err_sticky}, 32'd0);
      check({tag, ".err_count"}, {24'd0, err_count}, 32'd0);
      check({tag, ".enc_count"}, {16'd0, enc_count}, 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_kind   = 2'b00;
      in_ctrl   = 4'd0;
      out_ready = 1'b1;
      clr_err   = 1'b0;
      #2;
      check_reset_state("reset");
      #20;
      rst_n = 1'b1;
      tick();

      // Full legal table, one request per cycle, consumer always ready
      legal_vec(2'b00, 4'd0, 2'b00, 3'b000, 7'b0000000);
      legal_vec(2'b01, 4'd1, 2'b01, 3'b000, 7'b0000000);
      legal_vec(2'b10, 4'd0, 2'b10, 3'b000, 7'b0000000);
      legal_vec(2'b10, 4'd1, 2'b10, 3'b000, 7'b0100000);
      legal_vec(2'b10, 4'd2, 2'b10, 3'b111, 7'b0000000);
      legal_vec(2'b10, 4'd3, 2'b10, 3'b110, 7'b0000000);
      legal_vec(2'b10, 4'd4, 2'b10, 3'b100, 7'b0000000);
      legal_vec(2'b10, 4'd5, 2'b10, 3'b010, 7'b0000000);
      legal_vec(2'b10, 4'd6, 2'b10, 3'b011, 7'b0000000);
      legal_vec(2'b10, 4'd7, 2'b10, 3'b001, 7'b0000000);
      legal_vec(2'b10, 4'd8, 2'b10, 3'b101, 7'b0000000);
      legal_vec(2'b10, 4'd9, 2'b10, 3'b101, 7'b0100000);
      legal_vec(2'b11, 4'd0, 2'b11, 3'b000, 7'b0000000);
      legal_vec(2'b11, 4'd2, 2'b11, 3'b111, 7'b0000000);
      legal_vec(2'b11, 4'd3, 2'b11, 3'b110, 7'b0000000);
      legal_vec(2'b11, 4'd4, 2'b11, 3'b100, 7'b0000000);
      legal_vec(2'b11, 4'd5, 2'b11, 3'b010, 7'b0000000);
      legal_vec(2'b11, 4'd6, 2'b11, 3'b011, 7'b0000000);
      legal_vec(2'b11, 4'd7, 2'b11, 3'b001, 7'b0000000);
      legal_vec(2'b11, 4'd8, 2'b11, 3'b101, 7'b0000000);
      legal_vec(2'b11, 4'd9, 2'b11, 3'b101, 7'b0100000);
      in_valid = 1'b0;
      tick();
      check_head("drain", 1'b0, 2'b00, 3'b000, 7'b0000000);
      check("enc_after_table", {16'd0, enc_count}, 32'd21);
      check("err_after_table", {24'd0, err_count}, 32'd0);

      // Illegal requests are handshaked but never enqueued
      in_valid = 1'b1; in_kind = 2'b11; in_ctrl = 4'd1;
      check("illegal.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_kind = 2'b10; in_ctrl = 4'hC;
      tick();
      check("illegal2.out_valid", {31'd0, out_valid}, 32'd0);
      check("illegal2.err_count", {24'd0, err_count}, 32'd2);
      check("illegal2.err_sticky", {31'd0, err_sticky}, 32'd1);
      check("illegal2.enc_count", {16'd0, enc_count}, 32'd21);
      in_kind = 2'b00; in_ctrl = 4'd1;
      tick();
      in_kind = 2'b01; in_ctrl = 4'd0;
      tick();
      in_valid = 1'b0;
      check("illegal4.out_valid", {31'd0, out_valid}, 32'd0);
      check("illegal4.err_count", {24'd0, err_count}, 32'd4);

      // clr_err together with an illegal accept: set wins
      in_valid = 1'b1; in_kind = 2'b00; in_ctrl = 4'd5; clr_err = 1'b1;
      tick();
      check("clr_same.err_sticky", {31'd0, err_sticky}, 32'd1);
      check("clr_same.err_count", {24'd0, err_count}, 32'd5);
      in_valid = 1'b0;
      tick();
      check("clr_alone.err_sticky", {31'd0, err_sticky}, 32'd0);
      check("clr_alone.err_count", {24'd0, err_count}, 32'd5);
      clr_err = 1'b0;

      // Backpressure: fill a 2-entry queue, hold the third, then drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_kind = 2'b10; in_ctrl = 4'd0;
      tick();
      check("bp1.in_ready", {31'd0, in_ready}, 32'd1);
      check_head("bp1", 1'b1, 2'b10, 3'b000, 7'b0000000);
      in_kind = 2'b10; in_ctrl = 4'd1;
      tick();
      check("bp2.in_ready", {31'd0, in_ready}, 32'd0);
      check_head("bp2", 1'b1, 2'b10, 3'b000, 7'b0000000);
      in_kind = 2'b11; in_ctrl = 4'd9;
      tick();
      check("bp3.in_ready", {31'd0, in_ready}, 32'd0);
      check_head("bp3_hold", 1'b1, 2'b10, 3'b000, 7'b0000000);
      check("bp3.enc_count", {16'd0, enc_count}, 32'd23);
      out_ready = 1'b1;
      tick();
      check_head("bp4_second", 1'b1, 2'b10, 3'b000, 7'b0100000);
      check("bp4.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check_head("bp5_third", 1'b1, 2'b11, 3'b101, 7'b0100000);
      check("bp5.enc_count", {16'd0, enc_count}, 32'd24);
      in_valid = 1'b0;
      tick();
      check_head("bp6_empty", 1'b0, 2'b00, 3'b000, 7'b0000000);

      // Reset mid-operation with two entries queued takes effect without a clock edge
      out_ready = 1'b0;
      in_valid = 1'b1; in_kind = 2'b10; in_ctrl = 4'd3;
      tick();
      tick();
      in_valid = 1'b0;
      check("pre_rst.in_ready", {31'd0, in_ready}, 32'd0);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_state("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst.out_valid", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b1;
      legal_vec(2'b11, 4'd7, 2'b11, 3'b001, 7'b0000000);
      check("post_rst.enc_count", {16'd0, enc_count}, 32'd1);

      // enc_count wrap: 1 + 65534 + 2 = 65537 legal pushes since reset
      in_kind = 2'b10; in_ctrl = 4'd0;
      for (int i = 0; i < 65534; i++) tick();
      check("enc.ffff", {16'd0, enc_count}, 32'h0000FFFF);
      tick();
      check("enc.wrap0", {16'd0, enc_count}, 32'd0);
      tick();
      check("enc.wrap1", {16'd0, enc_count}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("enc.drained", {31'd0, out_valid}, 32'd0);

      // err_count saturation over 300 illegal accepts
      in_valid = 1'b1; in_kind = 2'b01; in_ctrl = 4'hF;
      for (int i = 0; i < 254; i++) tick();
      check("err.254", {24'd0, err_count}, 32'd254);
      for (int i = 0; i < 46; i++) tick();
      in_valid = 1'b0;
      check("err.sat", {24'd0, err_count}, 32'd255);
      check("err.sticky", {31'd0, err_sticky}, 32'd1);
      check("err.no_enq", {31'd0, out_valid}, 32'd0);
      check("err.enc_same", {16'd0, enc_count}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_ctrl_encoder.md
ALU_CTRL_ENCODER -- requirements
Module: alu_ctrl_encoder

Interface
REQ-001 SHALL have parameter: DEPTH, 2, output FIFO entries (power of two, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  request present.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid&&in_ready at clk edge.
REQ-006 SHALL have port: in_kind  input  2  00 mem-address, 01 branch, 10 R-type, 11 I-type.
REQ-007 SHALL have port: in_ctrl  input  4  ALUControl code (0000 ADD,0001 SUB,0010 AND,0011 OR,0100 XOR,0101 SLT,0110 SLTU,0111 SLL,1000 SRL,1001 SRA).
REQ-008 SHALL have port: out_valid  output  1  encoded entry at FIFO head.
REQ-009 SHALL have port: out_ready  input  1  consumer pops head when out_valid&&out_ready.
REQ-010 SHALL have ports: out_alu_op output 2, out_funct3 output 3, out_funct7 output 7  encoded fields of head entry.
REQ-011 SHALL have port: clr_err  input  1  synchronous clear of err_sticky.
REQ-012 SHALL have ports: err_sticky output 1, err_count output 8, enc_count output 16.

Function
REQ-013 SHALL encode in_kind=00 only with in_ctrl=ADD -> alu_op 00, funct3 000, funct7 0000000.
REQ-014 SHALL encode in_kind=01 only with in_ctrl=SUB -> alu_op 01, funct3 000, funct7 0000000.
REQ-015 SHALL encode in_kind=10 with alu_op 10; funct3: ADD/SUB 000, SLL 001, SLT 010, SLTU 011, XOR 100, SRL/SRA 101, OR 110, AND 111; funct7 0100000 for SUB and SRA, else 0000000.
REQ-016 SHALL encode in_kind=11 with alu_op 11 and the same funct3 table; funct7 0100000 only for SRA, else 0000000; SUB is illegal for kind 11.
REQ-017 SHALL treat as illegal: in_ctrl 1010-1111 (any kind), kind 00 with non-ADD, kind 01 with non-SUB, kind 11 with SUB.
REQ-018 SHALL complete the handshake for illegal requests but not enqueue them; set err_sticky and increment err_count on the following edge.
REQ-019 SHALL drive in_ready = 1 whenever FIFO occupancy < DEPTH, independent of in_valid and out_ready (no combinational path from out_ready).
REQ-020 SHALL make an accepted legal entry visible on out_valid on the cycle after acceptance when FIFO empty (1-cycle latency), no bypass.
REQ-021 SHALL hold out_* fields stable while out_valid=1 and out_ready=0.
REQ-022 SHALL preserve order; simultaneous push and pop when not full and not empty keeps occupancy unchanged; push and pop on a 1-entry FIFO keeps out_valid=1 with new head next cycle.
REQ-023 SHALL drive out_* fields to 0 when out_valid=0.
REQ-024 SHALL increment enc_count on each legal enqueue, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL saturate err_count at 0xFF.
REQ-026 SHALL clear err_sticky on clr_err unless an illegal request is accepted the same cycle (set wins); clr_err does not affect err_count.
REQ-027 SHALL have read/write pointers of log2(DEPTH) bits with a separate occupancy counter 0..DEPTH, wrapping pointers modulo DEPTH.

Reset
REQ-028 SHALL on rst_n=0 immediately (asynchronously) empty FIFO: out_valid=0, out_* =0, in_ready=1, err_sticky=0, err_count=0, enc_count=0.
REQ-029 SHALL discard all queued entries if reset asserts mid-operation; first accept after rst_n deasserts behaves as from empty.

Verification
REQ-030 SHALL verify full legal table: each (kind,ctrl) legal pair with out_ready=1 -> exact fields per REQ-013..016, e.g. kind 10 ctrl 1001 -> 10/101/0100000 one cycle later; kind 11 ctrl 0010 -> 11/111/0000000.
REQ-031 SHALL verify illegal: kind 11 ctrl 0001, then kind 10 ctrl 1100 -> nothing enqueued, err_count=2, err_sticky=1, enc_count unchanged.
REQ-032 SHALL verify backpressure: out_ready=0, push 3 legal with DEPTH=2 -> in_ready=0 after 2, third held; release out_ready -> entries emerge in order, third accepted.
REQ-033 SHALL verify clr_err and an illegal accept in same cycle -> err_sticky stays 1; clr_err alone next cycle -> 0.
REQ-034 SHALL verify saturation/wrap: 300 illegal requests -> err_count=255; 65537 legal pushes -> enc_count=1.
REQ-035 SHALL verify reset asserted with 2 entries queued -> out_valid=0 and counters 0 without a clock edge.
